// File: rtl/noc_pkg.sv
// Shared flit-format definitions and FSM states for the NOC route buffer.
package noc_pkg;

    localparam int FLIT_W  = 16;
    localparam int TYPE_HI = 15;
    localparam int TYPE_LO = 14;
    localparam int DEST_HI = 13;
    localparam int DEST_LO = 12;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_e;

    typedef enum logic {
        IDLE  = 1'b0,
        ROUTE = 1'b1
    } state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO; storage is not reset, only pointers and occupancy.
module noc_flit_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    // A push is refused when full even if a pop happens in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + CW'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/noc_route_buffer.sv
// Input flit buffer with route hold: decodes the head flit's destination and
// keeps it for the whole packet while feeding the 1-to-4 output demux.
module noc_route_buffer #(
    parameter int DEPTH  = 4,
    parameter int FLIT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              in_valid_i,
    input  logic [FLIT_W-1:0] in_data_i,
    output logic              in_ready_o,
    input  logic [3:0]        out_ready_i,
    output logic [FLIT_W-1:0] data_o,
    output logic [1:0]        sel_o,
    output logic              enable_o,
    output logic              err_o
);
    import noc_pkg::*;

    logic [FLIT_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    state_e            state_q;
    state_e            state_d;
    logic [1:0]        route_q;
    logic [1:0]        route_d;
    flit_type_e        front_type;
    logic [1:0]        front_dest;

    noc_flit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (in_valid_i),
        .wdata_i (in_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready_o = !fifo_full;
    // Masking the front when empty keeps data_o and the idle decode at zero.
    assign data_o     = fifo_empty ? '0 : fifo_rdata;
    assign front_type = flit_type_e'(data_o[TYPE_HI:TYPE_LO]);
    assign front_dest = data_o[DEST_HI:DEST_LO];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            route_q <= 2'b00;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        sel_o    = 2'b00;
        enable_o = 1'b0;
        err_o    = 1'b0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                sel_o = front_dest;
                if (!fifo_empty) begin
                    if (front_type == HEAD || front_type == SINGLE) begin
                        enable_o = 1'b1;
                        pop      = out_ready_i[front_dest];
                        if (pop && front_type == HEAD) begin
                            state_d = ROUTE;
                            route_d = front_dest;
                        end
                    end else begin
                        // Orphan body/tail: drop it without presenting.
                        pop   = 1'b1;
                        err_o = 1'b1;
                    end
                end
            end
            ROUTE: begin
                // Every flit, whatever its type field, follows the held route.
                sel_o    = route_q;
                enable_o = !fifo_empty;
                pop      = enable_o && out_ready_i[route_q];
                if (pop && front_type == TAIL) state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_noc_route_buffer.sv
// Scoreboard bench for noc_route_buffer: packet-level reference model feeds an
// expectation queue; a negedge monitor checks every presented or dropped flit.
module tb_noc_route_buffer;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic [3:0]  out_ready;
    logic [15:0] data_o;
    logic [1:0]  sel_o;
    logic        enable_o;
    logic        err_o;

    noc_route_buffer #(.DEPTH(DEPTH), .FLIT_W(16)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_ready_i (out_ready),
        .data_o      (data_o),
        .sel_o       (sel_o),
        .enable_o    (enable_o),
        .err_o       (err_o)
    );

    typedef struct {
        logic        err;
        logic [1:0]  port;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   occ      = 0;
    int   mode     = 0;
    logic m_in_pkt = 1'b0;
    logic [1:0] m_route = 2'b00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic fail_line(input string name, input logic [31:0] got, input logic [31:0] want);
        failures++;
        $display("FAIL %s actual=0x%0h required=0x%0h", name, got, want);
    endtask

    // Packet-level view: what should happen to each accepted flit, in order.
    task automatic model_push(input logic [15:0] f);
        exp_t e;
        e.data = f;
        e.err  = 1'b0;
        e.port = 2'b00;
        if (!m_in_pkt) begin
            if (f[15:14] == 2'b01) begin
                m_in_pkt = 1'b1;
                m_route  = f[13:12];
                e.port   = f[13:12];
            end else if (f[15:14] == 2'b11) begin
                e.port = f[13:12];
            end else begin
                e.err = 1'b1;
            end
        end else begin
            e.port = m_route;
            if (f[15:14] == 2'b10) m_in_pkt = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compares the front of the expectation queue every cycle.
    initial begin
        exp_t e;
        logic push_now;
        logic pop_now;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                occ = 0;
            end else begin
                checks++;
                if (in_ready !== (occ < DEPTH))
                    fail_line("in_ready", {31'd0, in_ready}, {31'd0, (occ < DEPTH)});
                push_now = in_valid && (occ < DEPTH);
                pop_now  = 1'b0;
                if (occ == 0) begin
                    checks++;
                    if (enable_o !== 1'b0 || err_o !== 1'b0 || data_o !== 16'h0)
                        fail_line("empty_outputs", {14'd0, enable_o, err_o, data_o}, 32'h0);
                end else if (exp_q.size() == 0) begin
                    checks++;
                    fail_line("scoreboard_underflow", occ, 0);
                end else begin
                    e = exp_q[0];
                    checks++;
                    if (e.err) begin
                        if (err_o !== 1'b1 || enable_o !== 1'b0)
                            fail_line("orphan_drop", {30'd0, enable_o, err_o}, 32'h1);
                        pop_now = 1'b1;
                    end else begin
                        if (enable_o !== 1'b1 || err_o !== 1'b0 || sel_o !== e.port || data_o !== e.data)
                            fail_line("flit_out", {12'd0, enable_o, err_o, sel_o, data_o},
                                      {12'd0, 1'b1, 1'b0, e.port, e.data});
                        pop_now = out_ready[e.port];
                    end
                    if (pop_now) void'(exp_q.pop_front());
                end
                occ = occ + int'(push_now) - int'(pop_now);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (mode == 1) out_ready = (out_ready == 4'h0) ? 4'hF : 4'h0;
        else if (mode == 2) out_ready = 4'($urandom_range(0, 15));
    endtask

    task automatic send_flit(input logic [15:0] f);
        in_valid = 1'b1;
        in_data  = f;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready) begin
                model_push(f);
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        checks++;
        fail_line("send_timeout", {16'd0, f}, 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 300; n++) begin
            if (occ == 0) return;
            step();
        end
        checks++;
        fail_line("drain_timeout", occ, 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        m_in_pkt = 1'b0;
        m_route  = 2'b00;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, enable_o, sel_o, data_o, err_o} !== {1'b1, 1'b0, 2'b00, 16'h0, 1'b0})
            fail_line("reset_values", {11'd0, in_ready, enable_o, sel_o, data_o, err_o},
                      {11'd0, 1'b1, 1'b0, 2'b00, 16'h0, 1'b0});
        step();
    endtask

    initial begin
        logic [15:0] f;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 4'h0;
        do_reset();

        // Single flit to port 3.
        out_ready = 4'b1000;
        send_flit(16'hF0A5);
        wait_drain();

        // Three-flit packet to port 2; body dest bits must not re-route.
        out_ready = 4'b0100;
        send_flit(16'h6001);
        send_flit(16'h0002);
        send_flit(16'h8003);
        wait_drain();

        // Backpressure: fill the FIFO, fifth flit held upstream.
        out_ready = 4'b0000;
        send_flit(16'h6111);
        send_flit(16'h0112);
        send_flit(16'h0113);
        send_flit(16'h0114);
        in_valid = 1'b1;
        in_data  = 16'h8115;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) fail_line("full_in_ready", {31'd0, in_ready}, 0);
            step();
        end
        out_ready = 4'b0100;
        send_flit(16'h8115);
        wait_drain();

        // Orphan body dropped, then a packet to port 1.
        out_ready = 4'b0010;
        send_flit(16'h0123);
        send_flit(16'h5000);
        send_flit(16'h8001);
        wait_drain();

        // Reset mid-packet with two flits still buffered.
        out_ready = 4'b0000;
        send_flit(16'h6ABC);
        send_flit(16'h0011);
        send_flit(16'h0022);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        do_reset();
        out_ready = 4'b0001;
        send_flit(16'hC0F0);
        wait_drain();

        // Pointer wrap with toggling downstream ready.
        mode      = 1;
        out_ready = 4'hF;
        send_flit(16'h7000);
        for (int i = 1; i <= 10; i++) send_flit(16'(i));
        send_flit(16'h800B);
        mode      = 0;
        out_ready = 4'hF;
        wait_drain();

        // Random flit types, destinations, gaps and per-port ready.
        mode = 2;
        for (int i = 0; i < 600; i++) begin
            f = 16'($urandom);
            send_flit(f);
            if ($urandom_range(0, 3) == 0) step();
        end
        mode      = 0;
        out_ready = 4'hF;
        step();
        wait_drain();
        step();

        checks++;
        if (exp_q.size() != 0) fail_line("leftover_expected", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_route_buffer.md
# noc_route_buffer

Input buffering and route-hold stage that sits directly upstream of the NOC 1-to-4 output demux. Accepts 16-bit flits from a link with a valid/ready handshake and stores them in a small FIFO. Decodes the destination port from each head flit and holds that route for the whole packet. Drives the demux `data`/`sel`/`enable` inputs, advancing only when the selected output port is ready.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `FLIT_W`, 16: flit width; fixed at 16 by the flit format below.

- `clk_i` in 1: single clock; all state updates on rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `in_valid_i` in 1: upstream flit valid.
- `in_data_i` in 16: upstream flit.
- `in_ready_o` out 1: buffer can accept; a transfer occurs when `in_valid_i && in_ready_o`.
- `out_ready_i` in 4: per-output-port ready from downstream; bit n for port n.
- `data_o` out 16: flit to demux `data_i`.
- `sel_o` out 2: port select to demux `sel_i`.
- `enable_o` out 1: demux `enable_i`; flit presented this cycle.
- `err_o` out 1: one-cycle pulse when an orphan body/tail flit is dropped.

## Operation
- Flit format: `[15:14]` type: 01 head, 00 body, 10 tail, 11 single (head+tail). On head/single flits, `[13:12]` = destination port. Remaining bits are payload and pass through untouched.
- FIFO: push when `in_valid_i && in_ready_o`; `in_ready_o = !full`. There is no push-when-full, even with a simultaneous pop. Occupancy counter is `$clog2(DEPTH)+1` bits; read/write pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: no route held.
    - `sel_o` = head-of-FIFO `[13:12]`.
    - `enable_o` = !empty and front flit type is head or single.
    - Front flit of type body or tail: popped without presenting (`enable_o`=0), `err_o`=1 that cycle, stay IDLE.
  - ROUTE: `sel_o` = `route_q`; `enable_o` = !empty.
- Pop condition: `pop = enable_o && out_ready_i[sel_o]`.
- Transitions:
  - IDLE→ROUTE: pop of a head flit; `route_q` ← its `[13:12]`.
  - IDLE→IDLE: pop of a single flit.
  - ROUTE→IDLE: pop of a tail flit.
  - A head or single flit arriving at the front while in ROUTE is forwarded as data on the held route; it is not re-decoded.
- `data_o` = front flit when !empty, else 16'h0000.

## Timing
- Reset (rst_n_i low at a rising edge):
  - FIFO emptied; state IDLE; `route_q`=0.
  - Outputs next cycle: `in_ready_o`=1, `enable_o`=0, `sel_o`=0, `data_o`=0, `err_o`=0.
  - Reset mid-packet discards all buffered flits and the held route.
- Latency: a flit pushed at edge t is at the FIFO front and visible on `data_o` after edge t. Minimum in→out is 1 cycle; no combinational in→out path.
- `data_o`, `sel_o`, and `enable_o` are combinational from FIFO/FSM state. They depend on `out_ready_i` only via pop; no output depends combinationally on `out_ready_i`.
- Simultaneous push and pop when not full: both occur; count unchanged.
- Full: `in_ready_o`=0 until the edge after a pop.
- Empty in ROUTE: `enable_o`=0, route held; the packet resumes when the next flit arrives.
- Sustained throughput: 1 flit/cycle when `out_ready_i[sel]` stays 1.

## Structure
- `noc_pkg`:
  - `FLIT_W`.
  - Flit type enum `flit_type_e` {BODY=2'b00, HEAD=2'b01, TAIL=2'b10, SINGLE=2'b11}.
  - Field position constants `TYPE_HI/LO`, `DEST_HI/LO`.
  - FSM state enum {IDLE, ROUTE}.
- Sub-module `noc_flit_fifo`: parameterised synchronous FIFO with push/pop, full/empty, and count. `noc_route_buffer` instantiates it and adds the FSM and route register.

## Test plan
- Reset then single flit 16'hF0A5 (SINGLE, dest 3), `out_ready_i`=4'b1000: after 1 cycle `enable_o`=1, `sel_o`=3, `data_o`=16'hF0A5. Popped; state stays IDLE; `enable_o`=0 next.
- Packet head 16'h6001 (dest 2), body 16'h0002, tail 16'h8003, with `out_ready_i`=4'b0100 constant: three consecutive cycles with `sel_o`=2 and the flits in order. Body 16'h0002 has `[13:12]`=0, yet `sel_o` stays 2.
- Backpressure: `out_ready_i`=0 while pushing 5 flits with DEPTH=4. `in_ready_o` drops after the 4th push; the 5th is held upstream; `enable_o`=1 with the front flit stable.
- Orphan body 16'h0123 arrives in IDLE: `err_o`=1 for one cycle, `enable_o`=0, flit discarded. A following head 16'h5000 (dest 1) is forwarded on port 1.
- Assert `rst_n_i`=0 one cycle after a head flit is popped (ROUTE, 2 flits buffered): next cycle empty, IDLE, all outputs at reset values. A following SINGLE dest 0 routes to port 0.
- Pointer wrap: stream 12 flits (head, 10 bodies, tail) with `out_ready_i` toggling 1/0 each cycle. All flits delivered in order, no loss or duplication, `err_o` never asserted.
